// File: rtl/lane_scan_mux_if.sv
// Bus for lane_scan_mux: lane sensors and HOLD in, scan state and window results out.
// MASK exists only when LANE_MASK_EN is defined.
interface lane_scan_mux_if #(
  parameter int CNT_W = 8
);
  logic             IP1;
  logic             IP2;
  logic             IP3;
  logic             IP4;
  logic             HOLD;
`ifdef LANE_MASK_EN
  logic [3:0]       MASK;
`endif
  logic [1:0]       SEL;
  logic             OP;
  logic             VALID;
  logic [1:0]       LANE;
  logic [CNT_W-1:0] DENSITY;

  modport master (
    output IP1, IP2, IP3, IP4, HOLD,
`ifdef LANE_MASK_EN
    output MASK,
`endif
    input  SEL, OP, VALID, LANE, DENSITY
  );

  modport slave (
    input  IP1, IP2, IP3, IP4, HOLD,
`ifdef LANE_MASK_EN
    input  MASK,
`endif
    output SEL, OP, VALID, LANE, DENSITY
  );
endinterface

// File: rtl/lane_scan_mux.sv
// Round-robin lane scanner: samples one lane per DWELL-cycle window and reports a saturating density.
// Optional lane skipping is built in when the macro LANE_MASK_EN is defined.
module lane_scan_mux #(
  parameter int DWELL = 16,
  parameter int CNT_W = 8
) (
  input  logic          CLK,
  input  logic          RST,
  lane_scan_mux_if.slave bus
);
  localparam logic [0:0] ST_SCAN   = 1'b0;
  localparam logic [0:0] ST_FROZEN = 1'b1;
  localparam logic [7:0] TICK_LAST = 8'(DWELL - 1);

  logic [0:0]       fsm_q, fsm_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       tick_q, tick_d;
  logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
  logic             op_q, op_d;
  logic             valid_q, valid_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] density_q, density_d;

  logic [3:0]       lane_in;
  logic             sample_bit;
  logic             sample_en;
  logic             hold_req;
  logic [1:0]       nxt_sel;

  assign lane_in    = {bus.IP4, bus.IP3, bus.IP2, bus.IP1};
  assign sample_bit = lane_in[sel_q];
  // Saturate instead of wrapping so a long dwell still reports a full lane.
  assign acc_inc    = (sample_bit && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;

`ifdef LANE_MASK_EN
  logic       idle_q, idle_d;
  logic       nxt_found;
  logic [1:0] lane_cand;

  // First unmasked lane strictly after SEL; SEL itself is the last candidate.
  always_comb begin
    nxt_sel   = sel_q;
    nxt_found = 1'b0;
    lane_cand = sel_q;
    for (int i = 4; i >= 1; i--) begin
      lane_cand = sel_q + 2'(i);
      if (!bus.MASK[lane_cand]) begin
        nxt_sel   = lane_cand;
        nxt_found = 1'b1;
      end
    end
  end

  // With every lane masked the scanner parks exactly as if HOLD were high.
  assign hold_req = bus.HOLD | idle_q;
`else
  assign nxt_sel  = sel_q + 2'd1;
  assign hold_req = bus.HOLD;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    fsm_d = fsm_q;
    case (fsm_q)
      ST_SCAN:   if (hold_req)  fsm_d = ST_FROZEN;
      ST_FROZEN: if (!hold_req) fsm_d = ST_SCAN;
      default:   fsm_d = ST_SCAN;
    endcase
  end

  // HOLD acts on the edge it is seen, so the sample due in that cycle is skipped.
  assign sample_en = (fsm_d == ST_SCAN);

  always_comb begin
    sel_d     = sel_q;
    tick_d    = tick_q;
    acc_d     = acc_q;
    valid_d   = 1'b0;
    lane_d    = lane_q;
    density_d = density_q;
    op_d      = sample_bit;
`ifdef LANE_MASK_EN
    idle_d    = idle_q;
`endif
    if (sample_en) begin
      if (tick_q == TICK_LAST) begin
        // Close the window and start the next lane on the very next edge.
        valid_d   = 1'b1;
        lane_d    = sel_q;
        density_d = acc_inc;
        tick_d    = '0;
        acc_d     = '0;
`ifdef LANE_MASK_EN
        if (nxt_found) sel_d  = nxt_sel;
        else           idle_d = 1'b1;
`else
        sel_d     = nxt_sel;
`endif
      end else begin
        tick_d = tick_q + 8'd1;
        acc_d  = acc_inc;
      end
    end
`ifdef LANE_MASK_EN
    else if (idle_q && nxt_found && !bus.HOLD) begin
      sel_d  = nxt_sel;
      idle_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q     <= ST_SCAN;
      sel_q     <= '0;
      tick_q    <= '0;
      acc_q     <= '0;
      op_q      <= 1'b0;
      valid_q   <= 1'b0;
      lane_q    <= '0;
      density_q <= '0;
`ifdef LANE_MASK_EN
      idle_q    <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
      fsm_q     <= fsm_d;
      sel_q     <= sel_d;
      tick_q    <= tick_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      lane_q    <= lane_d;
      density_q <= density_d;
`ifdef LANE_MASK_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign bus.SEL     = sel_q;
  assign bus.OP      = op_q;
  assign bus.VALID   = valid_q;
  assign bus.LANE    = lane_q;
  assign bus.DENSITY = density_q;
endmodule

// File: tb/tb_lane_scan_mux.sv
// Scoreboard bench for lane_scan_mux: directed phases push expected windows, negedge monitors pop and compare.
// Extra instances cover the small-counter and saturation cases; the mask phase is built only with LANE_MASK_EN.
module tb_lane_scan_mux;
  typedef struct {
    int lane;
    int density;
    int at;
  } exp_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic rst_bc = 1'b1;
  int   cyc    = 0;
  int   rel_m  = 0;
  int   rel_bc = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  exp_t sb_m[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  lane_scan_mux_if #(.CNT_W(8)) bus_m ();
  lane_scan_mux_if #(.CNT_W(4)) bus_b ();
  lane_scan_mux_if #(.CNT_W(4)) bus_c ();

  lane_scan_mux #(.DWELL(16), .CNT_W(8)) u_main (.CLK(clk), .RST(rst),    .bus(bus_m));
  lane_scan_mux #(.DWELL(4),  .CNT_W(4)) u_b    (.CLK(clk), .RST(rst_bc), .bus(bus_b));
  lane_scan_mux #(.DWELL(20), .CNT_W(4)) u_c    (.CLK(clk), .RST(rst_bc), .bus(bus_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_m(input int l, input int d, input int at);
    exp_t e;
    e.lane = l; e.density = d; e.at = at;
    sb_m.push_back(e);
  endtask

  task automatic set_ip(input logic [3:0] v);
    bus_m.IP1 = v[0];
    bus_m.IP2 = v[1];
    bus_m.IP3 = v[2];
    bus_m.IP4 = v[3];
  endtask

  // Called only at negedges where the main DUT has no VALID pending.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    rel_m = cyc;
  endtask

  // Main monitor: every VALID must match the head of the queue, including its edge number.
  always @(negedge clk) begin
    exp_t e;
    if (bus_m.VALID === 1'b1) begin
      if (sb_m.size() == 0) begin
        check("m_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_m.pop_front();
        check("m_lane",    32'(bus_m.LANE),    32'(e.lane));
        check("m_density", 32'(bus_m.DENSITY), 32'(e.density));
        check("m_edge",    32'(cyc - rel_m),   32'(e.at));
      end
    end
  end

  // The counter-width instances run freely; only their first windows are scored.
  always @(negedge clk) begin
    exp_t e;
    if (bus_b.VALID === 1'b1 && sb_b.size() > 0) begin
      e = sb_b.pop_front();
      check("b_lane",    32'(bus_b.LANE),    32'(e.lane));
      check("b_density", 32'(bus_b.DENSITY), 32'(e.density));
      check("b_edge",    32'(cyc - rel_bc),  32'(e.at));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_c.VALID === 1'b1 && sb_c.size() > 0) begin
      e = sb_c.pop_front();
      check("c_lane",    32'(bus_c.LANE),    32'(e.lane));
      check("c_density", 32'(bus_c.DENSITY), 32'(e.density));
      check("c_edge",    32'(cyc - rel_bc),  32'(e.at));
    end
  end

  initial begin
    exp_t e;
    set_ip(4'b0101);
    bus_m.HOLD = 1'b0;
    bus_b.IP1 = 1'b1; bus_b.IP2 = 1'b0; bus_b.IP3 = 1'b0; bus_b.IP4 = 1'b0; bus_b.HOLD = 1'b0;
    bus_c.IP1 = 1'b1; bus_c.IP2 = 1'b0; bus_c.IP3 = 1'b0; bus_c.IP4 = 1'b0; bus_c.HOLD = 1'b0;
`ifdef LANE_MASK_EN
    bus_m.MASK = 4'b0000;
    bus_b.MASK = 4'b0000;
    bus_c.MASK = 4'b0000;
`endif

    // Reset state while RST is held.
    repeat (2) @(negedge clk);
    check("rst_sel",     32'(bus_m.SEL),     32'd0);
    check("rst_op",      32'(bus_m.OP),      32'd0);
    check("rst_valid",   32'(bus_m.VALID),   32'd0);
    check("rst_lane",    32'(bus_m.LANE),    32'd0);
    check("rst_density", 32'(bus_m.DENSITY), 32'd0);

    // Lanes 1,0,1,0: the window closes on edge 16 after release, then every 16 edges.
    rst = 1'b0; rst_bc = 1'b0;
    rel_m = cyc; rel_bc = cyc;
    push_m(0, 16, 16); push_m(1, 0, 32); push_m(2, 16, 48); push_m(3, 0, 64); push_m(0, 16, 80);
    e = '{0, 4, 4};   sb_b.push_back(e);
    e = '{1, 0, 8};   sb_b.push_back(e);
    e = '{2, 0, 12};  sb_b.push_back(e);
    e = '{3, 0, 16};  sb_b.push_back(e);
    e = '{0, 4, 20};  sb_b.push_back(e);
    e = '{0, 15, 20}; sb_c.push_back(e);
    e = '{1, 0, 40};  sb_c.push_back(e);
    repeat (84) @(negedge clk);

    // HOLD over edges 16..20 skips tick 15 five times; the window closes on edge 21.
    set_ip(4'b0001);
    do_reset();
    push_m(0, 16, 21); push_m(1, 0, 37);
    repeat (15) @(negedge clk);
    bus_m.HOLD = 1'b1;
    for (int k = 16; k <= 20; k++) begin
      @(negedge clk);
      check("hold_sel", 32'(bus_m.SEL), 32'd0);
    end
    bus_m.HOLD = 1'b0;
    repeat (20) @(negedge clk);

    // Reset at tick 8 of lane 2 drops that window; VALID comes 16 edges after release,
    // i.e. in cycle 17 when the release cycle counts as cycle 1.
    set_ip(4'b1111);
    do_reset();
    push_m(0, 16, 16); push_m(1, 16, 32);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel",     32'(bus_m.SEL),     32'd0);
    check("midrst_valid",   32'(bus_m.VALID),   32'd0);
    check("midrst_density", 32'(bus_m.DENSITY), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    rel_m = cyc;
    push_m(0, 16, 16);
    repeat (20) @(negedge clk);

    // IP3 toggles while lane 2 is selected; OP lags it by one edge.
    set_ip(4'b0000);
    do_reset();
    push_m(0, 0, 16); push_m(1, 0, 32);
    repeat (32) @(negedge clk);
    begin
      logic ip3_prev;
      ip3_prev = 1'b0;
      for (int k = 32; k < 48; k++) begin
        if (k > 32) begin
          @(negedge clk);
          check("op_delay", 32'(bus_m.OP),  32'(ip3_prev));
          check("op_sel",   32'(bus_m.SEL), 32'd2);
        end
        ip3_prev  = ((k % 2) == 1);
        bus_m.IP3 = ip3_prev;
      end
    end

`ifdef LANE_MASK_EN
    // Lanes 0 and 2 masked: lane 0 runs first out of reset, then 1,3,1,3.
    // Masking everything mid-window lets that window finish, then scanning parks.
    set_ip(4'b1111);
    bus_m.MASK = 4'b0101;
    do_reset();
    push_m(0, 16, 16); push_m(1, 16, 32); push_m(3, 16, 48); push_m(1, 16, 64); push_m(3, 16, 80);
    push_m(1, 16, 96);
    repeat (88) @(negedge clk);
    bus_m.MASK = 4'b1111;
    repeat (62) @(negedge clk);
`endif

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("m_queue_drained", 32'(sb_m.size()), 32'd0);
    check("b_queue_drained", 32'(sb_b.size()), 32'd0);
    check("c_queue_drained", 32'(sb_c.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
